// File: rtl/rgb_led_sequencer.sv
// RGB LED controller: conditions two push buttons and runs the OFF/STATIC/CYCLE/BREATHE display FSM.
// Optional macro RGB_LED_SEQUENCER_GAMMA_EN squares the BREATHE duty for perceptually even fading.
module rgb_led_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_CYCLES     = 25000000,
  parameter int PWM_BITS        = 8,
  parameter int BREATHE_DIV     = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push_button0,
  input  logic       push_button1,
  output logic       led_red,
  output logic       led_green,
  output logic       led_blue,
  output logic [1:0] mode
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PER_W = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;

  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [DB_W-1:0]     DB_ONE    = DB_W'(32'd1);
  localparam logic [ST_W-1:0]     STEP_LAST = ST_W'(STEP_CYCLES - 32'sd1);
  localparam logic [ST_W-1:0]     STEP_ONE  = ST_W'(32'd1);
  localparam logic [PER_W-1:0]    PER_LAST  = PER_W'(BREATHE_DIV - 32'sd1);
  localparam logic [PER_W-1:0]    PER_ONE   = PER_W'(32'd1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(32'd1);
  localparam logic                DIR_UP    = 1'b0;
  localparam logic                DIR_DOWN  = 1'b1;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_STATIC  = 2'd1,
    ST_CYCLE   = 2'd2,
    ST_BREATHE = 2'd3
  } mode_e;

  function automatic logic [2:0] colour_next(input logic [2:0] c);
    if (c >= 3'd6) begin
      colour_next = 3'd0;
    end else begin
      colour_next = c + 3'd1;
    end
  endfunction

  function automatic logic [2:0] colour_rgb(input logic [2:0] c);
    case (c)
      3'd0:    colour_rgb = 3'b100;
      3'd1:    colour_rgb = 3'b010;
      3'd2:    colour_rgb = 3'b001;
      3'd3:    colour_rgb = 3'b110;
      3'd4:    colour_rgb = 3'b011;
      3'd5:    colour_rgb = 3'b101;
      3'd6:    colour_rgb = 3'b111;
      default: colour_rgb = 3'b000;
    endcase
  endfunction

  logic [1:0]          btn;
  logic [1:0]          sync1_q, sync2_q, vld_q;
  logic [1:0]          db_lvl_q, db_lvl_d, db_prev_q, arm_q, arm_d;
  logic [DB_W-1:0]     db_cnt_q [2];
  logic [DB_W-1:0]     db_cnt_d [2];
  logic [1:0]          press;
  mode_e               state_q, state_d;
  logic [2:0]          colour_q, colour_d;
  logic                paused_q, paused_d;
  logic [ST_W-1:0]     step_q, step_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d, duty_eff;
  logic [PER_W-1:0]    per_q, per_d;
  logic                dir_q, dir_d;
  logic                pwm_on;
  logic [2:0]          led_q, led_d;
  logic [1:0]          mode_q, mode_d;

  assign btn = {push_button1, push_button0};

  // Synchroniser, debounce and edge-detect state for both buttons
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      vld_q       <= 2'b00;
      db_lvl_q    <= 2'b00;
      db_prev_q   <= 2'b00;
      arm_q       <= 2'b00;
      db_cnt_q[0] <= {DB_W{1'b0}};
      db_cnt_q[1] <= {DB_W{1'b0}};
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      vld_q     <= {vld_q[0], 1'b1};
      db_lvl_q  <= db_lvl_d;
      db_prev_q <= db_lvl_q;
      arm_q     <= arm_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // Debounce counting; a button is armed only once it has been seen released after reset
  always_comb begin
    db_lvl_d = db_lvl_q;
    arm_d    = arm_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_lvl_q[i]) begin
        db_cnt_d[i] = {DB_W{1'b0}};
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i] = {DB_W{1'b0}};
        db_lvl_d[i] = sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
      end
      if (vld_q[1] && !sync2_q[i] && !db_lvl_q[i]) begin
        arm_d[i] = 1'b1;
      end else begin
        arm_d[i] = arm_q[i];
      end
    end
  end

  assign press = db_lvl_q & ~db_prev_q & arm_q;

  // Mode state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Mode transitions: only the mode button moves the FSM
  always_comb begin
    state_d = state_q;
    if (press[0]) begin
      case (state_q)
        ST_OFF:     state_d = ST_STATIC;
        ST_STATIC:  state_d = ST_CYCLE;
        ST_CYCLE:   state_d = ST_BREATHE;
        ST_BREATHE: state_d = ST_OFF;
        default:    state_d = ST_OFF;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Colour, cycle timer and breathing registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      colour_q <= 3'd0;
      paused_q <= 1'b0;
      step_q   <= {ST_W{1'b0}};
      pwm_q    <= {PWM_BITS{1'b0}};
      per_q    <= {PER_W{1'b0}};
      duty_q   <= {PWM_BITS{1'b0}};
      dir_q    <= DIR_UP;
    end else begin
      colour_q <= colour_d;
      paused_q <= paused_d;
      step_q   <= step_d;
      pwm_q    <= pwm_d;
      per_q    <= per_d;
      duty_q   <= duty_d;
      dir_q    <= dir_d;
    end
  end

  // Per-mode datapath updates; a mode press always wins over the action button
  always_comb begin
    colour_d = colour_q;
    paused_d = paused_q;
    step_d   = step_q;
    pwm_d    = pwm_q + DUTY_ONE;
    per_d    = per_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    case (state_q)
      ST_STATIC: begin
        if (press[0]) begin
          step_d   = {ST_W{1'b0}};
          paused_d = 1'b0;
        end else if (press[1]) begin
          colour_d = colour_next(colour_q);
        end else begin
          colour_d = colour_q;
        end
      end
      ST_CYCLE: begin
        if (press[0]) begin
          pwm_d  = {PWM_BITS{1'b0}};
          per_d  = {PER_W{1'b0}};
          duty_d = {PWM_BITS{1'b0}};
          dir_d  = DIR_UP;
        end else begin
          if (paused_q) begin
            step_d = step_q;
          end else if (step_q == STEP_LAST) begin
            step_d   = {ST_W{1'b0}};
            colour_d = colour_next(colour_q);
          end else begin
            step_d = step_q + STEP_ONE;
          end
          if (press[1]) begin
            paused_d = ~paused_q;
          end else begin
            paused_d = paused_q;
          end
        end
      end
      ST_BREATHE: begin
        if (press[0]) begin
          colour_d = colour_q;
        end else begin
          if (press[1]) begin
            colour_d = colour_next(colour_q);
          end else begin
            colour_d = colour_q;
          end
          if (pwm_q != PWM_MAX) begin
            per_d = per_q;
          end else if (per_q != PER_LAST) begin
            per_d = per_q + PER_ONE;
          end else begin
            per_d = {PER_W{1'b0}};
            // Turn around on reaching either end so the triangle never overshoots
            if (dir_q == DIR_UP) begin
              if (duty_q >= PWM_MAX - DUTY_ONE) begin
                duty_d = PWM_MAX;
                dir_d  = DIR_DOWN;
              end else begin
                duty_d = duty_q + DUTY_ONE;
                dir_d  = DIR_UP;
              end
            end else begin
              if (duty_q <= DUTY_ONE) begin
                duty_d = {PWM_BITS{1'b0}};
                dir_d  = DIR_UP;
              end else begin
                duty_d = duty_q - DUTY_ONE;
                dir_d  = DIR_DOWN;
              end
            end
          end
        end
      end
      default: begin
        colour_d = colour_q;
      end
    endcase
  end

`ifdef RGB_LED_SEQUENCER_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_sq  = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
  assign duty_eff = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_eff = duty_q;
`endif

  assign pwm_on = (pwm_q < duty_eff);

  // Output decode from the registered mode and colour
  always_comb begin
    case (state_q)
      ST_OFF:     led_d = 3'b000;
      ST_STATIC:  led_d = colour_rgb(colour_q);
      ST_CYCLE:   led_d = colour_rgb(colour_q);
      ST_BREATHE: led_d = colour_rgb(colour_q) & {3{pwm_on}};
      default:    led_d = 3'b000;
    endcase
    mode_d = state_q;
  end

  // Output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q  <= 3'b000;
      mode_q <= 2'd0;
    end else begin
      led_q  <= led_d;
      mode_q <= mode_d;
    end
  end

  assign led_red   = led_q[2];
  assign led_green = led_q[1];
  assign led_blue  = led_q[0];
  assign mode      = mode_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Self-checking bench for rgb_led_sequencer: randomized directed steps against a mode/colour/timing reference model.
module tb_rgb_led_sequencer;

  localparam int D   = 4;
  localparam int S   = 8;
  localparam int P   = 4;
  localparam int B   = 1;
  localparam int PER = 1 << P;
  localparam int MAXD = PER - 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       push_button0 = 1'b0;
  logic       push_button1 = 1'b0;
  logic       led_red, led_green, led_blue;
  logic [1:0] mode;

  rgb_led_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .STEP_CYCLES    (S),
    .PWM_BITS       (P),
    .BREATHE_DIV    (B)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_button0(push_button0),
    .push_button1(push_button1),
    .led_red     (led_red),
    .led_green   (led_green),
    .led_blue    (led_blue),
    .mode        (mode)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;
  int p0_edge  = -1;
  int p1_edge  = -1;

  // Reference model: mode, colour index, CYCLE timer/pause, cycles spent in BREATHE
  int m_mode   = 0;
  int m_colour = 0;
  int m_tmr    = 0;
  int m_bt     = 0;
  bit m_paused = 1'b0;
  logic [1:0] e_mode;
  logic [2:0] e_led;
  logic [2:0] rgb_tab [7] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111};

  function automatic int tri_duty(int k);
    int t;
    t = k % (2 * MAXD);
    return (t <= MAXD) ? t : (2 * MAXD - t);
  endfunction

  function automatic int eff_duty(int d);
`ifdef RGB_LED_SEQUENCER_GAMMA_EN
    return (d * d) >> P;
`else
    return d;
`endif
  endfunction

  function automatic logic [2:0] model_leds();
    case (m_mode)
      1, 2:    return rgb_tab[m_colour];
      3:       return ((m_bt % PER) < eff_duty(tri_duty(m_bt / (PER * B)))) ? rgb_tab[m_colour] : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_colour = 0; m_tmr = 0; m_bt = 0; m_paused = 1'b0;
    p0_edge = -1; p1_edge = -1;
  endtask

  task automatic model_step(bit p0, bit p1);
    case (m_mode)
      0: if (p0) m_mode = 1;
      1: begin
        if (p0) begin m_mode = 2; m_tmr = 0; m_paused = 1'b0; end
        else if (p1) m_colour = (m_colour + 1) % 7;
      end
      2: begin
        if (p0) begin
          m_mode = 3; m_bt = 0;
        end else begin
          if (!m_paused) begin
            m_tmr++;
            if (m_tmr == S) begin m_tmr = 0; m_colour = (m_colour + 1) % 7; end
          end
          if (p1) m_paused = !m_paused;
        end
      end
      default: begin
        if (p0) m_mode = 0;
        else begin
          m_bt++;
          if (p1) m_colour = (m_colour + 1) % 7;
        end
      end
    endcase
  endtask

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, act, exp, edge_no);
    end
  endtask

  // One clock: outputs take the value implied by the pre-edge model state, then the model advances
  task automatic tick();
    bit p0, p1;
    @(posedge clock);
    edge_no++;
    if (!reset_n) begin
      model_reset();
      e_mode = 2'd0;
      e_led  = 3'b000;
    end else begin
      e_mode = 2'(m_mode);
      e_led  = model_leds();
      p0 = (edge_no == p0_edge);
      p1 = (edge_no == p1_edge);
      model_step(p0, p1);
    end
    #1;
    check("mode", 32'(mode), 32'(e_mode));
    check("leds", 32'({led_red, led_green, led_blue}), 32'(e_led));
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Clean press: a stable rise reaches the FSM D+3 edges later (outputs one edge after that)
  task automatic press(bit b0, bit b1, int hold, int gap);
    if (b0) begin push_button0 = 1'b1; p0_edge = edge_no + D + 3; end
    if (b1) begin push_button1 = 1'b1; p1_edge = edge_no + D + 3; end
    ticks(hold);
    push_button0 = 1'b0;
    push_button1 = 1'b0;
    ticks(gap);
  endtask

  initial begin
    int n;
    ticks(3);
    reset_n = 1'b1;
    ticks(20);

    // OFF -> STATIC, then short glitches on both buttons
    press(1'b1, 1'b0, $urandom_range(8, 12), $urandom_range(10, 14));
    for (int i = 0; i < 3; i++) begin
      push_button0 = 1'b1; ticks($urandom_range(1, 3));
      push_button0 = 1'b0; ticks(8);
    end
    for (int i = 0; i < 2; i++) begin
      push_button1 = 1'b1; ticks($urandom_range(1, 3));
      push_button1 = 1'b0; ticks(8);
    end

    // Seven colour steps in STATIC, wrapping back to red
    for (int i = 0; i < 7; i++) press(1'b0, 1'b1, $urandom_range(6, 12), $urandom_range(10, 14));

    // CYCLE: free run, pause, resume
    press(1'b1, 1'b0, 10, 56);
    press(1'b0, 1'b1, 10, 40);
    press(1'b0, 1'b1, 10, $urandom_range(20, 40));

    // BREATHE: steer colour back to red, then run past a full triangle
    press(1'b1, 1'b0, 10, 10);
    n = (7 - m_colour) % 7;
    for (int i = 0; i < n; i++) press(1'b0, 1'b1, 8, 12);
    ticks(520);

    // BREATHE -> OFF -> STATIC, then both buttons in the same cycle
    press(1'b1, 1'b0, 10, 12);
    press(1'b1, 1'b0, 10, 12);
    press(1'b0, 1'b1, 10, 12);
    press(1'b1, 1'b1, 10, $urandom_range(15, 30));

    // Asynchronous reset mid-CYCLE: outputs clear without a clock edge
    #1;
    reset_n = 1'b0;
    #1;
    check("async_mode", 32'(mode), 32'd0);
    check("async_leds", 32'({led_red, led_green, led_blue}), 32'd0);
    model_reset();
    ticks(2);
    reset_n = 1'b1;
    ticks(10);

    // Button held through reset release gives no event until re-pressed
    reset_n = 1'b0;
    push_button0 = 1'b1;
    ticks(3);
    reset_n = 1'b1;
    ticks(30);
    push_button0 = 1'b0;
    ticks(12);
    press(1'b1, 1'b0, 10, 10);
    check("held_then_pressed", 32'(mode), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_led_sequencer.md
Name: rgb_led_sequencer

Overview:
- Controller for the on-board RGB LED.
- Conditions the two active-high push-button levels: synchronise, debounce, rising-edge detect.
- Runs a display-mode FSM and drives active-high led_red/led_green/led_blue.
- Sits between the button polarity wrapper and the LED polarity wrapper, replacing ad-hoc LED logic in the main module.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles before a new button level is accepted (>=2).
- STEP_CYCLES, 25000000: clocks per colour step in CYCLE mode (>=2).
- PWM_BITS, 8: PWM counter and duty width.
- BREATHE_DIV, 64: PWM periods per duty step in BREATHE mode (>=1).

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- push_button0  in  1  mode button, active-high, asynchronous to clock.
- push_button1  in  1  action button, active-high, asynchronous to clock.
- led_red  out  1  red LED on, active-high, registered.
- led_green  out  1  green LED on, active-high, registered.
- led_blue  out  1  blue LED on, active-high, registered.
- mode  out  2  current FSM state: 0 OFF, 1 STATIC, 2 CYCLE, 3 BREATHE; registered.

Behaviour:

Reset:
- Reset is asynchronous active-low: one clock, reset_n asserted low clears all flops immediately; deassertion is used synchronously.
- Reset values: mode=OFF, colour=0, paused=0, duty=0, dir=up, all counters 0, debounced levels 0, all LED outputs 0.
- Reset mid-press or mid-sequence discards all state; a button held through reset release gives no event until it is released and pressed again.

Input conditioning:
- Per button: 2-flop synchroniser, then a debounce counter.
- The counter clears whenever the synchronised level equals the debounced level.
- The debounced level flips when DEBOUNCE_CYCLES consecutive differing samples are seen.
- Press event = 1-cycle pulse on a debounced 0->1 transition. Release produces no event.

Colour index (3 bits, RGB): 0 R(100), 1 G(010), 2 B(001), 3 Y(110), 4 C(011), 5 M(101), 6 W(111); index wraps 6->0.

FSM:
- press0: OFF->STATIC->CYCLE->BREATHE->OFF.
- press1 in OFF: ignored.
- press1 in STATIC: colour+1 with wrap.
- press1 in CYCLE: toggle paused.
- press1 in BREATHE: colour+1 with wrap.
- press0 and press1 in the same cycle: press0 acts, press1 is dropped.
- Colour index is retained across mode changes.

CYCLE mode:
- Entering CYCLE clears the step timer and paused.
- Step timer counts 0..STEP_CYCLES-1; at terminal count, colour+1 with wrap and timer returns to 0.
- While paused, the timer holds its value.
- press1 at terminal count in the same cycle: the step still applies and paused toggles.

BREATHE mode:
- Entering BREATHE clears duty to 0, sets dir=up and clears the PWM counter.
- PWM counter is free-running, PWM_BITS wide.
- A period counter counts PWM wraps; every BREATHE_DIV wraps, duty moves +/-1.
- At 2^PWM_BITS-1 going up, dir flips to down (no overshoot); at 0 going down, dir flips to up. Triangle wave.
- LED channel on = colour bit & (pwm_cnt < duty_eff).

Other modes:
- STATIC: LEDs = colour bits, steady.
- OFF: LEDs = 000.

Latency:
- Outputs are registered one clock after the FSM/colour update.
- Input rise stable from cycle 0 -> LED/mode change at cycle DEBOUNCE_CYCLES+4, constant.

Optional Feature:
- Macro: RGB_LED_SEQUENCER_GAMMA_EN.
- Defined: BREATHE uses duty_eff = (duty*duty)>>PWM_BITS, computed combinationally from the registered duty, for perceptually even fading.
- Not defined: duty_eff = duty (linear).
- Other modes, mode output and latency are identical either way.

Test Plan (DEBOUNCE_CYCLES=4, STEP_CYCLES=8, PWM_BITS=4, BREATHE_DIV=1):
- Reset then idle 20 cycles -> mode=0, LEDs=000 throughout; reset_n low mid-CYCLE -> LEDs=000 and mode=0 in the same cycle, no clock edge needed.
- Clean press0 held 10 cycles -> mode=1, LEDs=100 exactly 8 cycles after rise; 3 glitches of 1-3 cycles -> no change.
- In STATIC, 7 clean press1 -> LEDs step 010,001,110,011,101,111,100 (wrap).
- Two press0 into CYCLE, run 56 cycles -> colour advances every 8 cycles; press1 -> freezes for 40 cycles; press1 -> resumes from held timer value.
- press0 and press1 rising in the same cycle from STATIC -> mode=2, colour unchanged.
- BREATHE at colour 0: duty 0 -> LED low whole period; duty 15 -> high 15 of 16 cycles; duty reverses after 15. With GAMMA_EN: duty 8 gives 4 high cycles per 16.
